// File: rtl/cordic_scheduler_pkg.sv
// Shared definitions for the CORDIC request scheduler.
// Holds default widths, the requester limit and the FSM state encoding.
package cordic_scheduler_pkg;

    localparam int W_DEF    = 13;
    localparam int NREQ_DEF = 4;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_scheduler_if.sv
// Bundle of requester-side and core-side signals around the CORDIC scheduler.
// Modports:
//   slave  - scheduler view: takes req_*, rsp_ready and cordic_ready/pm/am,
//            drives req_ready, cordic_enable/i/q, rsp_valid/pm/am/err.
//   master - environment view (requesters plus the CORDIC core).
interface cordic_scheduler_if
    import cordic_scheduler_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_i;
    logic [NREQ*W-1:0] req_q;
    logic [NREQ-1:0]   req_ready;
    logic              cordic_enable;
    logic [W-1:0]      cordic_i;
    logic [W-1:0]      cordic_q;
    logic              cordic_ready;
    logic [W-1:0]      cordic_pm;
    logic [W-1:0]      cordic_am;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_pm;
    logic [W-1:0]      rsp_am;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_i, req_q,
        input  cordic_ready, cordic_pm, cordic_am,
        input  rsp_ready,
        output req_ready, cordic_enable, cordic_i, cordic_q,
        output rsp_valid, rsp_pm, rsp_am, rsp_err
    );

    modport master (
        output req_valid, req_i, req_q,
        output cordic_ready, cordic_pm, cordic_am,
        output rsp_ready,
        input  req_ready, cordic_enable, cordic_i, cordic_q,
        input  rsp_valid, rsp_pm, rsp_am, rsp_err
    );

endinterface

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request from i_ptr upward.
// Ports: i_req (requests), i_ptr (start index), o_grant (one-hot),
//        o_idx (encoded grant), o_any (some request is set).
module cordic_scheduler_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    logic [PW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC core among NREQ requesters in round-robin order.
// Ports: CLK, RESET (async, active-high), bus (cordic_scheduler_if.slave).
// Optional CORDIC_TIMEOUT_EN adds a WAIT watchdog reporting rsp_err.
module cordic_scheduler
    import cordic_scheduler_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    cordic_scheduler_if.slave   bus
);

    localparam int PW = $clog2(NREQ);

    state_t          r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    logic            r_enable;
    logic [W-1:0]    r_ci;
    logic [W-1:0]    r_cq;
    logic [W-1:0]    r_pm;
    logic [W-1:0]    r_am;
    logic [NREQ-1:0] r_rsp_valid;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_any;

    cordic_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grant is only offered while idle and out of reset.
    assign bus.req_ready     = (r_state == S_IDLE && !RESET) ? w_grant : '0;
    assign bus.cordic_enable = r_enable;
    assign bus.cordic_i      = r_ci;
    assign bus.cordic_q      = r_cq;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_pm        = r_pm;
    assign bus.rsp_am        = r_am;

`ifdef CORDIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign bus.rsp_err = r_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_enable    <= 1'b0;
            r_ci        <= '0;
            r_cq        <= '0;
            r_pm        <= '0;
            r_am        <= '0;
            r_rsp_valid <= '0;
`ifdef CORDIC_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_enable <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ci     <= bus.req_i[w_idx*W +: W];
                        r_cq     <= bus.req_q[w_idx*W +: W];
                        r_owner  <= w_idx;
                        r_rr_ptr <= (w_idx == PW'(NREQ - 1))
                                  ? '0 : w_idx + 1'b1;
                        r_enable <= 1'b1;
                        r_state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef CORDIC_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A core result on the expiry cycle takes priority.
                    if (bus.cordic_ready) begin
                        r_pm        <= bus.cordic_pm;
                        r_am        <= bus.cordic_am;
                        r_rsp_valid <= NREQ'(1) << r_owner;
                        r_state     <= S_RESP;
`ifdef CORDIC_TIMEOUT_EN
                        r_err       <= 1'b0;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_pm        <= '0;
                        r_am        <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= NREQ'(1) << r_owner;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
